mat_loader: RTL and testbench

- Upstream feeder for the matrix-multiply stage.
- Accepts a row-serial stream of signed W_IN-bit elements and assembles two complete N×N operand matrices (matrix_1, then matrix_2).
- Presents both matrices, plus the captured mode bit, to the multiplier through a valid/ready handshake.
- Supports weight-stationary reuse: matrix_2 is kept from the previous frame when requested, so only matrix_1 rows are streamed.

---
 rtl/mat_pkg.sv | 20 ++
 rtl/mat_row_store.sv | 28 ++
 rtl/mat_loader.sv | 154 +++++++++++++++
 tb/tb_mat_loader.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mat_pkg.sv
// Shared types and defaults for the matrix-multiply datapath.
//   W_IN  : signed input element width
//   N     : matrix dimension
//   W_OUT : accumulator width used by the downstream multiplier
package mat_pkg;

    localparam int unsigned W_IN  = 8;
    localparam int unsigned N     = 8;
    localparam int unsigned W_OUT = 2 * W_IN + $clog2(N);

    typedef logic signed [N-1:0][W_IN-1:0] row_t;
    typedef row_t [N-1:0]                  mat_in_t;

    typedef enum logic [1:0] {
        LOAD_A,
        LOAD_B,
        PRESENT
    } ld_state_e;

endpackage

// File: rtl/mat_row_store.sv
// N-row register file written one row at a time.
//   clk, rstn : clock, async active-low reset (clears all rows)
//   we, idx   : write enable and row index
//   wdata     : row to write, column 0 in the LSBs
//   rows      : full stored matrix, index [row][col]
module mat_row_store #(
    parameter int unsigned W_IN = mat_pkg::W_IN,
    parameter int unsigned N    = mat_pkg::N,
    localparam int unsigned CW  = (N > 1) ? $clog2(N) : 1
) (
    input  logic                             clk,
    input  logic                             rstn,
    input  logic                             we,
    input  logic [CW-1:0]                    idx,
    input  logic [N-1:0][W_IN-1:0]           wdata,
    output logic [N-1:0][N-1:0][W_IN-1:0]    rows
);

    // Row write; contents otherwise held
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rows <= '0;
        end else if (we) begin
            rows[idx] <= wdata;
        end
    end

endmodule

// File: rtl/mat_loader.sv
// Assembles two NxN operand matrices from a row-serial stream and hands them
// to the multiplier over a valid/ready handshake. matrix_2 may be reused from
// the previous frame (weight-stationary), in which case only A rows stream.
//   clk, rstn             : clock, async active-low reset
//   flush                 : synchronous abort of the current frame
//   s_valid/s_ready       : row stream handshake; s_data one row, s_last frame end
//   s_mode, s_reuse_b     : sampled on the first beat of a frame
//   m_valid/m_ready       : matrices-ready handshake
//   matrix_1, matrix_2    : operands A and B, index [row][col]
//   mode_out              : captured mode bit
//   err                   : sticky framing error
module mat_loader #(
    parameter int unsigned W_IN = mat_pkg::W_IN,
    parameter int unsigned N    = mat_pkg::N
) (
    input  logic                                 clk,
    input  logic                                 rstn,
    input  logic                                 flush,
    input  logic                                 s_valid,
    output logic                                 s_ready,
    input  logic [N*W_IN-1:0]                    s_data,
    input  logic                                 s_last,
    input  logic                                 s_mode,
    input  logic                                 s_reuse_b,
    output logic                                 m_valid,
    input  logic                                 m_ready,
    output logic signed [N-1:0][N-1:0][W_IN-1:0] matrix_1,
    output logic signed [N-1:0][N-1:0][W_IN-1:0] matrix_2,
    output logic                                 mode_out,
    output logic                                 err
);

    import mat_pkg::*;

    localparam int unsigned   CW       = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST_ROW = CW'(N - 1);

    ld_state_e     state_q, state_d;
    logic [CW-1:0] row_cnt_q, row_cnt_d;
    logic          b_loaded_q, b_loaded_d;
    logic          reuse_q, reuse_d;
    logic          mode_d;
    logic          err_d;
    logic          we_a, we_b;
    logic          reuse_eff;
    logic          beat;
    logic          last_row;

    assign beat     = s_valid && s_ready;
    assign last_row = (row_cnt_q == LAST_ROW);

    // State and control registers; handshake outputs follow the next state
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= LOAD_A;
            row_cnt_q  <= '0;
            b_loaded_q <= 1'b0;
            reuse_q    <= 1'b0;
            mode_out   <= 1'b0;
            err        <= 1'b0;
            m_valid    <= 1'b0;
            s_ready    <= 1'b1;
        end else begin
            state_q    <= state_d;
            row_cnt_q  <= row_cnt_d;
            b_loaded_q <= b_loaded_d;
            reuse_q    <= reuse_d;
            mode_out   <= mode_d;
            err        <= err_d;
            m_valid    <= (state_d == PRESENT);
            s_ready    <= (state_d != PRESENT);
        end
    end

    // Next-state, row write enables and framing check
    always_comb begin
        state_d    = state_q;
        row_cnt_d  = row_cnt_q;
        b_loaded_d = b_loaded_q;
        reuse_d    = reuse_q;
        mode_d     = mode_out;
        err_d      = err;
        we_a       = 1'b0;
        we_b       = 1'b0;
        reuse_eff  = reuse_q;

        if (flush) begin
            state_d   = LOAD_A;
            row_cnt_d = '0;
            err_d     = 1'b0;
        end else begin
            case (state_q)
                LOAD_A: begin
                    if (beat) begin
                        we_a      = 1'b1;
                        row_cnt_d = last_row ? '0 : row_cnt_q + CW'(1);
                        // First-beat sampling must also feed this beat's decision (N=1)
                        if (row_cnt_q == '0) begin
                            mode_d    = s_mode;
                            reuse_d   = s_reuse_b && b_loaded_q;
                            reuse_eff = reuse_d;
                        end
                        if (s_last != (last_row && reuse_eff)) begin
                            err_d = 1'b1;
                        end
                        if (last_row) begin
                            state_d = reuse_eff ? PRESENT : LOAD_B;
                        end
                    end
                end
                LOAD_B: begin
                    if (beat) begin
                        we_b      = 1'b1;
                        row_cnt_d = last_row ? '0 : row_cnt_q + CW'(1);
                        if (s_last != last_row) begin
                            err_d = 1'b1;
                        end
                        if (last_row) begin
                            b_loaded_d = 1'b1;
                            state_d    = PRESENT;
                        end
                    end
                end
                PRESENT: begin
                    if (m_ready) begin
                        state_d = LOAD_A;
                    end
                end
                default: begin
                    state_d = LOAD_A;
                end
            endcase
        end
    end

    mat_row_store #(.W_IN(W_IN), .N(N)) u_store_a (
        .clk   (clk),
        .rstn  (rstn),
        .we    (we_a),
        .idx   (row_cnt_q),
        .wdata (s_data),
        .rows  (matrix_1)
    );

    mat_row_store #(.W_IN(W_IN), .N(N)) u_store_b (
        .clk   (clk),
        .rstn  (rstn),
        .we    (we_b),
        .idx   (row_cnt_q),
        .wdata (s_data),
        .rows  (matrix_2)
    );

endmodule

// File: tb/tb_mat_loader.sv
module tb_mat_loader;

    localparam int N = 8;
    localparam int W = 8;

    typedef logic [N-1:0][N-1:0][W-1:0] mat_t;
    typedef struct {
        mat_t m1;
        mat_t m2;
        logic mode;
        logic err;
    } exp_t;

    logic                              clk;
    logic                              rstn;
    logic                              flush;
    logic                              s_valid;
    logic                              s_ready;
    logic [N*W-1:0]                    s_data;
    logic                              s_last;
    logic                              s_mode;
    logic                              s_reuse_b;
    logic                              m_valid;
    logic                              m_ready;
    logic signed [N-1:0][N-1:0][W-1:0] matrix_1;
    logic signed [N-1:0][N-1:0][W-1:0] matrix_2;
    logic                              mode_out;
    logic                              err;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    mat_t cur_b;
    bit   b_loaded_tb;

    mat_loader #(.W_IN(W), .N(N)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .flush     (flush),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_data    (s_data),
        .s_last    (s_last),
        .s_mode    (s_mode),
        .s_reuse_b (s_reuse_b),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .matrix_1  (matrix_1),
        .matrix_2  (matrix_2),
        .mode_out  (mode_out),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic mat_t ramp(input int off);
        mat_t m;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                m[r][c] = W'(r * N + c + off);
        return m;
    endfunction

    function automatic mat_t ident();
        mat_t m;
        m = '0;
        for (int i = 0; i < N; i++) m[i][i] = W'(1);
        return m;
    endfunction

    function automatic mat_t const_mat(input logic [W-1:0] v);
        mat_t m;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                m[r][c] = v;
        return m;
    endfunction

    // Drive one row from a negedge; returns at the negedge after the beat
    task automatic send_row(input logic [N*W-1:0] d, input logic last, input logic mode,
                            input logic reuse, input int gap_pct);
        int waited;
        while (int'($urandom_range(0, 99)) < gap_pct) begin
            s_valid = 1'b0;
            @(negedge clk);
        end
        s_valid   = 1'b1;
        s_data    = d;
        s_last    = last;
        s_mode    = mode;
        s_reuse_b = reuse;
        waited    = 0;
        while (s_ready !== 1'b1 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 50) chk("s_ready_wait", {s_ready}, 1);
        @(negedge clk);
        s_valid   = 1'b0;
        s_last    = 1'b0;
        s_reuse_b = 1'b0;
    endtask

    task automatic send_frame(input mat_t a, input mat_t b, input logic mode, input logic reuse,
                              input int last_idx, input int gap_pct, input string tag);
        bit             eff;
        int             n;
        exp_t           e;
        logic [N*W-1:0] row;
        eff    = reuse && b_loaded_tb;
        n      = eff ? N : 2 * N;
        e.m1   = a;
        e.m2   = eff ? cur_b : b;
        e.mode = mode;
        e.err  = (last_idx != n - 1);
        sb.push_back(e);
        if (!eff) begin
            cur_b       = b;
            b_loaded_tb = 1'b1;
        end
        for (int i = 0; i < n; i++) begin
            row = (i < N) ? a[i] : b[i-N];
            send_row(row, i == last_idx, (i == 0) ? mode : ~mode, (i == 0) ? reuse : ~reuse, gap_pct);
            if (i < n - 1) chk({tag, "_early_valid"}, {m_valid}, 0);
            else           chk({tag, "_latency"}, {m_valid}, 1);
        end
    endtask

    task automatic check_present(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 0, 1);
        end else begin
            e = sb.pop_front();
            chk({tag, "_m_valid"}, {m_valid}, 1);
            chk({tag, "_matrix_1"}, {matrix_1}, e.m1);
            chk({tag, "_matrix_2"}, {matrix_2}, e.m2);
            chk({tag, "_mode_out"}, {mode_out}, {e.mode});
            chk({tag, "_err"}, {err}, {e.err});
        end
    endtask

    task automatic release_frame(input string tag);
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
        chk({tag, "_rel_m_valid"}, {m_valid}, 0);
        chk({tag, "_rel_s_ready"}, {s_ready}, 1);
    endtask

    initial begin
        mat_t           snap1, snap2, junk;
        logic [N*W-1:0] row;

        rstn = 1'b0; flush = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
        s_mode = 1'b0; s_reuse_b = 1'b0; m_ready = 1'b0;
        b_loaded_tb = 1'b0; cur_b = '0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_m_valid", {m_valid}, 0);
        chk("rst_err", {err}, 0);
        chk("rst_mode_out", {mode_out}, 0);
        chk("rst_matrix_1", {matrix_1}, 0);
        chk("rst_matrix_2", {matrix_2}, 0);
        rstn = 1'b1;
        @(negedge clk);
        chk("rst_s_ready", {s_ready}, 1);

        // Basic A+B frame
        send_frame(ramp(0), ident(), 1'b1, 1'b0, 2 * N - 1, 0, "basic");
        check_present("basic");
        chk("basic_m1_3_5", {matrix_1[3][5]}, 29);
        for (int i = 0; i < N; i++) chk("basic_m2_diag", {matrix_2[i][i]}, 1);

        // Backpressure: everything held while m_ready is low
        snap1 = matrix_1;
        snap2 = matrix_2;
        repeat (10) begin
            @(negedge clk);
            chk("bp_s_ready", {s_ready}, 0);
            chk("bp_m_valid", {m_valid}, 1);
            chk("bp_matrix_1", {matrix_1}, snap1);
            chk("bp_matrix_2", {matrix_2}, snap2);
        end
        release_frame("bp");

        // Reuse of stored B: only 8 A rows
        send_frame(const_mat(8'hFF), '0, 1'b0, 1'b1, N - 1, 0, "reuse");
        check_present("reuse");
        chk("reuse_m1_0_0", {matrix_1[0][0]}, 8'hFF);
        release_frame("reuse");

        // Gapped input must give the same result as the gap-free frame
        send_frame(ramp(0), ident(), 1'b1, 1'b0, 2 * N - 1, 50, "gapped");
        check_present("gapped");
        release_frame("gapped");

        // Early s_last sets err; flush clears it and keeps B
        junk = ramp(7);
        for (int i = 0; i < 6; i++) begin
            row = junk[i];
            send_row(row, i == 2, 1'b0, 1'b0, 0);
            if (i == 2) chk("flush_err_set", {err}, 1);
        end
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("flush_err", {err}, 0);
        chk("flush_m_valid", {m_valid}, 0);
        chk("flush_s_ready", {s_ready}, 1);
        send_frame(ramp(3), '0, 1'b1, 1'b1, N - 1, 0, "post_flush");
        check_present("post_flush");
        release_frame("post_flush");

        // Async reset mid-frame, then reuse request with no stored B
        junk = ramp(200);
        for (int i = 0; i < 5; i++) begin
            row = junk[i];
            send_row(row, 1'b0, 1'b1, 1'b0, 0);
        end
        rstn = 1'b0;
        #1;
        chk("midrst_matrix_1", {matrix_1}, 0);
        chk("midrst_matrix_2", {matrix_2}, 0);
        chk("midrst_err", {err}, 0);
        chk("midrst_m_valid", {m_valid}, 0);
        @(negedge clk);
        rstn = 1'b1;
        b_loaded_tb = 1'b0;
        cur_b = '0;
        @(negedge clk);
        send_frame(ramp(100), ramp(50), 1'b1, 1'b1, N - 1, 0, "reuse_no_b");
        check_present("reuse_no_b");
        release_frame("reuse_no_b");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
